// File: rtl/dma_ctrl.sv
// dma_ctrl: single-channel Z80 DMA sequencer moving byte blocks between one I/O port and RAM.
// Latency: bus request one clock after START; each byte costs 2*(WAIT_CYCLES+1)+2 clocks once granted.
// Backpressure: stalls in REQ until busak_n is sampled low; holds the bus for the whole block.
// Optional feature macro: DMA_IRQ_EN adds int_n and CTRL bit3 IRQEN.
module dma_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cs_i,
    input  logic        ioreq_n,
    input  logic        wr_n,
    input  logic [7:0]  addr_i,
    input  logic [7:0]  data_i,
    output logic [7:0]  data_o,
    output logic        busrq_n,
    input  logic        busak_n,
    output logic        dma_active,
    output logic [15:0] dma_addr_o,
    output logic [7:0]  dma_data_o,
    input  logic [7:0]  dma_data_i,
    output logic        dma_mreq_n,
    output logic        dma_ioreq_n,
    output logic        dma_rd_n,
    output logic        dma_wr_n
`ifdef DMA_IRQ_EN
    ,
    output logic        int_n
`endif
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_NEXT = 3'd5;
    localparam logic [2:0] S_REL  = 3'd6;

    localparam logic [7:0] A_MEM_LO = 8'h74;
    localparam logic [7:0] A_MEM_HI = 8'h75;
    localparam logic [7:0] A_IOPORT = 8'h76;
    localparam logic [7:0] A_LEN_LO = 8'h77;
    localparam logic [7:0] A_LEN_HI = 8'h78;
    localparam logic [7:0] A_CTRL   = 8'h79;
    localparam logic [7:0] A_STATUS = 8'h7A;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [2:0]  state, state_d;
    logic [15:0] mem, mem_d;
    logic [7:0]  ioport, ioport_d;
    logic [15:0] len, len_d;
    logic        dir, dir_d;
    logic        ioinc, ioinc_d;
    logic        busy, busy_d;
    logic        done, done_d;
    logic        aborted, aborted_d;
    logic        abort_pend, abort_pend_d;
    logic [3:0]  wcnt, wcnt_d;
    logic        wstb, wstb_q, wr_en;
    logic        rd_phase, wr_phase, bus_held, bus_owned;
`ifdef DMA_IRQ_EN
    logic        irqen, irqen_d;
`endif

    // A register write lands only on the first cycle of the CPU write strobe.
    assign wstb  = cs_i & ~ioreq_n & ~wr_n;
    assign wr_en = wstb & ~wstb_q;

    // Next-state logic: CPU register writes, then the transfer sequencer.
    always_comb begin
        state_d      = state;
        mem_d        = mem;
        ioport_d     = ioport;
        len_d        = len;
        dir_d        = dir;
        ioinc_d      = ioinc;
        busy_d       = busy;
        done_d       = done;
        aborted_d    = aborted;
        abort_pend_d = abort_pend;
        wcnt_d       = wcnt;
`ifdef DMA_IRQ_EN
        irqen_d      = irqen;
`endif

        // Configuration is frozen while a block is in flight.
        if (wr_en && !busy) begin
            case (addr_i)
                A_MEM_LO: mem_d[7:0]  = data_i;
                A_MEM_HI: mem_d[15:8] = data_i;
                A_IOPORT: ioport_d    = data_i;
                A_LEN_LO: len_d[7:0]  = data_i;
                A_LEN_HI: len_d[15:8] = data_i;
                A_CTRL: begin
                    dir_d   = data_i[1];
                    ioinc_d = data_i[2];
`ifdef DMA_IRQ_EN
                    irqen_d = data_i[3];
`endif
                end
                default: ;
            endcase
        end

        if (wr_en && addr_i == A_STATUS) begin
            done_d    = 1'b0;
            aborted_d = 1'b0;
        end

        // ABORT only means something while busy; it waits for the current byte to finish.
        if (wr_en && addr_i == A_CTRL && data_i[7] && busy)
            abort_pend_d = 1'b1;

        case (state)
            S_IDLE: begin
                if (wr_en && addr_i == A_CTRL && data_i[0]) begin
                    done_d    = 1'b0;
                    aborted_d = 1'b0;
                    if (len == 16'h0000) begin
                        // Empty block: finish through REL without touching the bus.
                        state_d = S_REL;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (abort_pend) begin
                    state_d = S_REL;
                end else if (!busak_n) begin
                    state_d = S_RD;
                    wcnt_d  = WAIT_INIT;
                end
            end
            S_RD: begin
                if (wcnt == 4'd0) state_d = S_GAP;
                else              wcnt_d  = wcnt - 4'd1;
            end
            S_GAP: begin
                state_d = S_WR;
                wcnt_d  = WAIT_INIT;
            end
            S_WR: begin
                if (wcnt == 4'd0) state_d = S_NEXT;
                else              wcnt_d  = wcnt - 4'd1;
            end
            S_NEXT: begin
                len_d = len - 16'd1;
                mem_d = mem + 16'd1;
                if (ioinc) ioport_d = ioport + 8'd1;
                if (len_d == 16'h0000 || abort_pend) begin
                    state_d = S_REL;
                end else begin
                    state_d = S_RD;
                    wcnt_d  = WAIT_INIT;
                end
            end
            S_REL: begin
                state_d      = S_IDLE;
                busy_d       = 1'b0;
                done_d       = 1'b1;
                aborted_d    = abort_pend;
                abort_pend_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so every strobe comes straight off a flop.
    assign rd_phase  = (state_d == S_RD);
    assign wr_phase  = (state_d == S_WR);
    assign bus_owned = (state_d == S_RD) || (state_d == S_GAP) ||
                       (state_d == S_WR) || (state_d == S_NEXT);
    assign bus_held  = bus_owned || (state_d == S_REQ);

    // State, configuration and registered bus outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= S_IDLE;
            mem         <= 16'h0000;
            ioport      <= 8'h00;
            len         <= 16'h0000;
            dir         <= 1'b0;
            ioinc       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            abort_pend  <= 1'b0;
            wcnt        <= 4'd0;
            wstb_q      <= 1'b0;
            busrq_n     <= 1'b1;
            dma_active  <= 1'b0;
            dma_addr_o  <= 16'h0000;
            dma_data_o  <= 8'h00;
            dma_mreq_n  <= 1'b1;
            dma_ioreq_n <= 1'b1;
            dma_rd_n    <= 1'b1;
            dma_wr_n    <= 1'b1;
`ifdef DMA_IRQ_EN
            irqen       <= 1'b0;
            int_n       <= 1'b1;
`endif
        end else begin
            state       <= state_d;
            mem         <= mem_d;
            ioport      <= ioport_d;
            len         <= len_d;
            dir         <= dir_d;
            ioinc       <= ioinc_d;
            busy        <= busy_d;
            done        <= done_d;
            aborted     <= aborted_d;
            abort_pend  <= abort_pend_d;
            wcnt        <= wcnt_d;
            wstb_q      <= wstb;
            busrq_n     <= ~bus_held;
            dma_active  <= bus_owned;
            dma_rd_n    <= ~rd_phase;
            dma_wr_n    <= ~wr_phase;
            // DIR=0 reads the port and writes memory; DIR=1 the reverse.
            dma_mreq_n  <= ~((rd_phase & dir) | (wr_phase & ~dir));
            dma_ioreq_n <= ~((rd_phase & ~dir) | (wr_phase & dir));
            if (rd_phase)
                dma_addr_o <= dir ? mem_d : {8'h00, ioport_d};
            else if (wr_phase)
                dma_addr_o <= dir ? {8'h00, ioport_d} : mem_d;
            // Capture the source byte on the last read clock; it stays on the bus until the next one.
            if (state == S_RD && wcnt == 4'd0)
                dma_data_o <= dma_data_i;
`ifdef DMA_IRQ_EN
            irqen       <= irqen_d;
            int_n       <= ~(done_d & irqen_d);
`endif
        end
    end

    // Register readback; live counters are visible during a transfer.
    always_comb begin
        data_o = 8'h00;
        if (cs_i && !ioreq_n) begin
            case (addr_i)
                A_MEM_LO: data_o = mem[7:0];
                A_MEM_HI: data_o = mem[15:8];
                A_IOPORT: data_o = ioport;
                A_LEN_LO: data_o = len[7:0];
                A_LEN_HI: data_o = len[15:8];
`ifdef DMA_IRQ_EN
                A_CTRL:   data_o = {4'b0000, irqen, ioinc, dir, 1'b0};
`else
                A_CTRL:   data_o = {5'b00000, ioinc, dir, 1'b0};
`endif
                A_STATUS: data_o = {5'b00000, aborted, done, busy};
                default:  data_o = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_ctrl.sv
// tb_dma_ctrl: register-table checks plus scoreboarded DMA transfers for dma_ctrl.
// A bus monitor pops expected read/write cycles from a queue as the strobes fall.
// The bus arbiter grants busak_n two clocks after busrq_n falls unless held off.
module tb_dma_ctrl;

    localparam int W = 1;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        cs_i = 1'b0;
    logic        ioreq_n = 1'b1;
    logic        wr_n = 1'b1;
    logic [7:0]  addr_i = 8'h00;
    logic [7:0]  data_i = 8'h00;
    logic [7:0]  data_o;
    logic        busrq_n;
    logic        busak_n = 1'b1;
    logic        dma_active;
    logic [15:0] dma_addr_o;
    logic [7:0]  dma_data_o;
    logic [7:0]  dma_data_i = 8'h00;
    logic        dma_mreq_n, dma_ioreq_n, dma_rd_n, dma_wr_n;
`ifdef DMA_IRQ_EN
    logic        int_n;
    localparam logic [7:0] CTRL_B3 = 8'h08;
`else
    localparam logic [7:0] CTRL_B3 = 8'h00;
`endif

    dma_ctrl #(.WAIT_CYCLES(W)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .cs_i        (cs_i),
        .ioreq_n     (ioreq_n),
        .wr_n        (wr_n),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .data_o      (data_o),
        .busrq_n     (busrq_n),
        .busak_n     (busak_n),
        .dma_active  (dma_active),
        .dma_addr_o  (dma_addr_o),
        .dma_data_o  (dma_data_o),
        .dma_data_i  (dma_data_i),
        .dma_mreq_n  (dma_mreq_n),
        .dma_ioreq_n (dma_ioreq_n),
        .dma_rd_n    (dma_rd_n),
        .dma_wr_n    (dma_wr_n)
`ifdef DMA_IRQ_EN
        ,.int_n      (int_n)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        is_wr;
        logic [15:0] addr;
        logic        io;
        logic [7:0]  dat;
    } ev_t;

    ev_t exp_q[$];
    int  exp_rd = 0;
    int  rd_events = 0, wr_events = 0;
    int  cyc = 0, last_rd_cyc = -1, rd_w = 0, wr_w = 0;
    logic prev_rd = 1'b1, prev_wr = 1'b1;
    logic busrq_seen = 1'b0;

    task automatic push_byte(input logic [15:0] src, input logic src_io,
                             input logic [15:0] dst, input logic dst_io);
        exp_q.push_back(ev_t'{is_wr: 1'b0, addr: src, io: src_io, dat: 8'h00});
        exp_q.push_back(ev_t'{is_wr: 1'b1, addr: dst, io: dst_io, dat: 8'hC0 + 8'(exp_rd)});
        exp_rd++;
    endtask

    task automatic check_event(input logic is_wr);
        ev_t e;
        chk("bus_cycle_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk(is_wr ? "wr_kind" : "rd_kind", is_wr, e.is_wr);
        chk(is_wr ? "wr_addr" : "rd_addr", dma_addr_o, e.addr);
        chk(is_wr ? "wr_ioreq" : "rd_ioreq", !dma_ioreq_n, e.io);
        chk(is_wr ? "wr_mreq" : "rd_mreq", !dma_mreq_n, !e.io);
        if (is_wr) chk("wr_data", dma_data_o, e.dat);
    endtask

    // Bus monitor: checks each cycle against the queue, strobe widths and byte period.
    always @(negedge clk_i) begin
        cyc++;
        if (!rst_n_i) begin
            prev_rd = 1'b1;
            prev_wr = 1'b1;
            last_rd_cyc = -1;
        end else begin
            if (!busrq_n) busrq_seen = 1'b1;
            if (!dma_active) last_rd_cyc = -1;
            if (prev_rd && !dma_rd_n) begin
                check_event(1'b0);
                if (last_rd_cyc >= 0) chk("byte_period", cyc - last_rd_cyc, 2 * (W + 1) + 2);
                last_rd_cyc = cyc;
                dma_data_i = 8'hC0 + 8'(rd_events);
                rd_events++;
                rd_w = 1;
            end else if (!prev_rd && !dma_rd_n) rd_w++;
            else if (!prev_rd && dma_rd_n) chk("rd_width", rd_w, W + 1);
            if (prev_wr && !dma_wr_n) begin
                check_event(1'b1);
                wr_events++;
                wr_w = 1;
            end else if (!prev_wr && !dma_wr_n) wr_w++;
            else if (!prev_wr && dma_wr_n) chk("wr_width", wr_w, W + 1);
            prev_rd = dma_rd_n;
            prev_wr = dma_wr_n;
        end
    end

    // Bus arbiter model.
    int grant_cnt = 0;
    logic grant_hold = 1'b0;
    always @(negedge clk_i) begin
        if (busrq_n || !rst_n_i) begin
            grant_cnt = 0;
            busak_n = 1'b1;
        end else begin
            grant_cnt++;
            if (grant_cnt >= 2 && !grant_hold) busak_n = 1'b0;
        end
    end

    // ---------------- CPU access ----------------
    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d, input logic sel);
        @(negedge clk_i);
        cs_i = sel; ioreq_n = 1'b0; wr_n = 1'b0; addr_i = a; data_i = d;
        @(negedge clk_i);
        cs_i = 1'b0; ioreq_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic cpu_read(input logic [7:0] a, output logic [7:0] d);
        cs_i = 1'b1; ioreq_n = 1'b0; wr_n = 1'b1; addr_i = a;
        #1;
        d = data_o;
        cs_i = 1'b0; ioreq_n = 1'b1;
    endtask

    task automatic read_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] r;
        cpu_read(a, r);
        chk(name, r, exp);
    endtask

    task automatic wait_idle(input int budget);
        logic [7:0] s;
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            cpu_read(8'h7A, s);
            n++;
        end while (s[0] && n < budget);
        chk("xfer_done_in_budget", s[0], 0);
    endtask

    task automatic setup(input logic [15:0] mem, input logic [7:0] port,
                         input logic [15:0] len, input logic [7:0] ctrl);
        cpu_write(8'h74, mem[7:0], 1'b1);
        cpu_write(8'h75, mem[15:8], 1'b1);
        cpu_write(8'h76, port, 1'b1);
        cpu_write(8'h77, len[7:0], 1'b1);
        cpu_write(8'h78, len[15:8], 1'b1);
        cpu_write(8'h79, ctrl, 1'b1);
    endtask

    typedef struct {
        logic       wr;
        logic       sel;
        logic [7:0] addr;
        logic [7:0] wdat;
        logic [7:0] rexp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] r;
        int base, n;

        vecs[0]  = '{1'b0, 1'b1, 8'h7A, 8'h00, 8'h00};
        vecs[1]  = '{1'b1, 1'b1, 8'h74, 8'h34, 8'h34};
        vecs[2]  = '{1'b1, 1'b1, 8'h75, 8'h12, 8'h12};
        vecs[3]  = '{1'b1, 1'b1, 8'h77, 8'h03, 8'h03};
        vecs[4]  = '{1'b1, 1'b1, 8'h78, 8'h00, 8'h00};
        vecs[5]  = '{1'b1, 1'b1, 8'h76, 8'h80, 8'h80};
        vecs[6]  = '{1'b1, 1'b0, 8'h74, 8'hFF, 8'h34};
        vecs[7]  = '{1'b1, 1'b1, 8'h79, 8'h06, 8'h06};
        vecs[8]  = '{1'b1, 1'b1, 8'h79, 8'h0E, 8'h06 | CTRL_B3};
        vecs[9]  = '{1'b1, 1'b1, 8'h79, 8'h00, 8'h00};
        vecs[10] = '{1'b0, 1'b1, 8'h7B, 8'h00, 8'h00};
        vecs[11] = '{1'b0, 1'b1, 8'h73, 8'h00, 8'h00};

        // Reset state.
        repeat (3) @(negedge clk_i);
        chk("reset_ctrl_outs", {busrq_n, dma_active, dma_mreq_n, dma_ioreq_n, dma_rd_n, dma_wr_n}, 6'b101111);
        chk("reset_addr", dma_addr_o, 16'h0000);
        chk("reset_data", dma_data_o, 8'h00);
        #1 rst_n_i = 1'b1;

        // Register access table.
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) cpu_write(vecs[i].addr, vecs[i].wdat, vecs[i].sel);
            cpu_read(vecs[i].addr, r);
            chk($sformatf("reg_vec%0d", i), r, vecs[i].rexp);
        end

        // Held write strobe: only the first cycle's data lands.
        @(negedge clk_i);
        cs_i = 1'b1; ioreq_n = 1'b0; wr_n = 1'b0; addr_i = 8'h76; data_i = 8'h11;
        @(negedge clk_i);
        data_i = 8'h22;
        @(negedge clk_i);
        cs_i = 1'b0; ioreq_n = 1'b1; wr_n = 1'b1;
        read_chk("write_edge_only", 8'h76, 8'h11);

        // IO->mem, 3 bytes from port 0x80 into 0x1234.., config locked while busy.
        setup(16'h1234, 8'h80, 16'd3, 8'h00);
        for (int k = 0; k < 3; k++) push_byte(16'h0080, 1'b1, 16'h1234 + 16'(k), 1'b0);
        cpu_write(8'h79, 8'h01, 1'b1);
        cpu_write(8'h74, 8'h99, 1'b1);
        wait_idle(200);
        read_chk("t1_status", 8'h7A, 8'h02);
        read_chk("t1_len_lo", 8'h77, 8'h00);
        read_chk("t1_mem_lo", 8'h74, 8'h37);
        chk("t1_bus_released", {busrq_n, dma_active}, 2'b10);
        chk("t1_queue_empty", exp_q.size(), 0);

        // mem->IO with address and port wrap.
        setup(16'hFFFF, 8'hFF, 16'd2, 8'h06);
        push_byte(16'hFFFF, 1'b0, 16'h00FF, 1'b1);
        push_byte(16'h0000, 1'b0, 16'h0000, 1'b1);
        cpu_write(8'h79, 8'h07, 1'b1);
        wait_idle(200);
        read_chk("t2_status", 8'h7A, 8'h02);
        read_chk("t2_mem_lo", 8'h74, 8'h01);
        read_chk("t2_mem_hi", 8'h75, 8'h00);
        read_chk("t2_ioport", 8'h76, 8'h01);
        chk("t2_queue_empty", exp_q.size(), 0);

        // START with LEN=0: DONE cleared by START, set next clock, no bus request.
        cpu_write(8'h77, 8'h00, 1'b1);
        cpu_write(8'h78, 8'h00, 1'b1);
        busrq_seen = 1'b0;
        cpu_write(8'h79, 8'h01, 1'b1);
        read_chk("len0_done_cleared", 8'h7A, 8'h00);
        @(negedge clk_i);
        read_chk("len0_done_next", 8'h7A, 8'h02);
        repeat (3) @(negedge clk_i);
        chk("len0_no_busrq", busrq_seen, 1'b0);

        // ABORT during the second read: byte 2 completes, then release.
        setup(16'h2000, 8'h40, 16'd10, 8'h00);
        push_byte(16'h0040, 1'b1, 16'h2000, 1'b0);
        push_byte(16'h0040, 1'b1, 16'h2001, 1'b0);
        base = rd_events;
        cpu_write(8'h79, 8'h01, 1'b1);
        n = 0;
        while (rd_events < base + 2 && n < 200) begin
            @(negedge clk_i); #1; n++;
        end
        chk("abort_reached_rd2", 32'(rd_events >= base + 2), 1);
        cpu_write(8'h79, 8'h80, 1'b1);
        wait_idle(200);
        read_chk("abort_status", 8'h7A, 8'h06);
        read_chk("abort_len_lo", 8'h77, 8'h08);
        read_chk("abort_len_hi", 8'h78, 8'h00);
        read_chk("abort_mem_lo", 8'h74, 8'h02);
        chk("abort_queue_empty", exp_q.size(), 0);
        cpu_write(8'h7A, 8'h00, 1'b1);
        read_chk("status_clear", 8'h7A, 8'h00);

        // ABORT while waiting for the grant: no bus cycles at all.
        grant_hold = 1'b1;
        base = rd_events;
        cpu_write(8'h77, 8'h05, 1'b1);
        cpu_write(8'h79, 8'h01, 1'b1);
        repeat (3) @(negedge clk_i);
        #1 chk("req_waiting", {busrq_n, dma_active}, 2'b00);
        cpu_write(8'h79, 8'h80, 1'b1);
        wait_idle(50);
        read_chk("req_abort_status", 8'h7A, 8'h06);
        read_chk("req_abort_len", 8'h77, 8'h05);
        chk("req_abort_no_reads", rd_events - base, 0);
        chk("req_abort_released", busrq_n, 1'b1);
        grant_hold = 1'b0;

`ifdef DMA_IRQ_EN
        // Interrupt: asserted while DONE & IRQEN, cleared by STATUS write.
        cpu_write(8'h77, 8'h00, 1'b1);
        cpu_write(8'h79, 8'h09, 1'b1);
        @(negedge clk_i); #1;
        chk("irq_asserted", int_n, 1'b0);
        cpu_write(8'h7A, 8'h00, 1'b1);
        #1 chk("irq_cleared", int_n, 1'b1);
`endif

        // Reset in the middle of a write cycle.
        setup(16'h3000, 8'h10, 16'd4, 8'h00);
        push_byte(16'h0010, 1'b1, 16'h3000, 1'b0);
        base = wr_events;
        cpu_write(8'h79, 8'h01, 1'b1);
        n = 0;
        while (wr_events == base && n < 200) begin
            @(negedge clk_i); #1; n++;
        end
        chk("reset_reached_wr", 32'(wr_events != base), 1);
        #1 rst_n_i = 1'b0;
        #1 chk("async_reset_outs", {busrq_n, dma_active, dma_mreq_n, dma_ioreq_n, dma_rd_n, dma_wr_n}, 6'b101111);
        repeat (2) @(negedge clk_i);
        #1 rst_n_i = 1'b1;
        read_chk("post_reset_status", 8'h7A, 8'h00);
        read_chk("post_reset_len", 8'h77, 8'h00);
        chk("post_reset_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
